// File: rtl/frame_pkg.sv
// Shared constants and types for the windowed frame-pointer controller.
// Optional feature macro: FP_BOUNDS_CHECK_EN (rejects calls/returns that leave 0..15).
package frame_pkg;

    localparam int ADDR_W      = 4;
    localparam int WIN_W       = 3;
    localparam int NUM_REGS    = 16;
    localparam int WIN_SIZE    = 8;
    localparam int STACK_DEPTH = 4;
    localparam int DEPTH_W     = $clog2(STACK_DEPTH + 1);

    typedef enum logic {
        IDLE,
        MOVE
    } fp_state_t;

    typedef logic [ADDR_W-1:0]  phys_addr_t;
    typedef logic [WIN_W-1:0]   win_idx_t;
    typedef logic [DEPTH_W-1:0] depth_t;

endpackage

// File: rtl/frame_ptr_ctrl_if.sv
// Decode-side bundle of the frame-pointer controller.
// master = decode/register-file side, slave = frame_ptr_ctrl.
interface frame_ptr_ctrl_if;
    import frame_pkg::*;

    logic       Call_Req;
    logic       Rtn_Req;
    win_idx_t   Call_Shift;
    win_idx_t   Rd_Rel;
    win_idx_t   Rs_Rel;
    win_idx_t   Rm_Rel;
    logic       Rd_Wen_In;
    logic       Rs_Wen_In;

    phys_addr_t Rd_Addr;
    phys_addr_t Rs_Addr;
    phys_addr_t Rm_Addr;
    win_idx_t   Actual_Rd;
    win_idx_t   Actual_Rs;
    win_idx_t   Actual_Rm;
    logic       Rd_Wen;
    logic       Rs_Wen;
    logic       FP_move;
    logic       FP_push_up;
    phys_addr_t New_FP;
    phys_addr_t FP;
    logic       Busy;
    depth_t     Depth;
    logic       Fault;

    modport master (
        output Call_Req, Rtn_Req, Call_Shift,
        output Rd_Rel, Rs_Rel, Rm_Rel,
        output Rd_Wen_In, Rs_Wen_In,
        input  Rd_Addr, Rs_Addr, Rm_Addr,
        input  Actual_Rd, Actual_Rs, Actual_Rm,
        input  Rd_Wen, Rs_Wen,
        input  FP_move, FP_push_up, New_FP, FP,
        input  Busy, Depth, Fault
    );

    modport slave (
        input  Call_Req, Rtn_Req, Call_Shift,
        input  Rd_Rel, Rs_Rel, Rm_Rel,
        input  Rd_Wen_In, Rs_Wen_In,
        output Rd_Addr, Rs_Addr, Rm_Addr,
        output Actual_Rd, Actual_Rs, Actual_Rm,
        output Rd_Wen, Rs_Wen,
        output FP_move, FP_push_up, New_FP, FP,
        output Busy, Depth, Fault
    );

endinterface

// File: rtl/fp_shift_stack.sv
// LIFO of call shifts; overflowing push and underflowing pop are ignored.
module fp_shift_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic [W-1:0]                 din,
    output logic [W-1:0]                 top,
    output logic [$clog2(DEPTH+1)-1:0]   depth,
    output logic                         full,
    output logic                         empty
);

    localparam int DW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [DW-1:0] depth_q;
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] rd_idx;

    assign wr_idx = IW'(depth_q);
    assign rd_idx = IW'(depth_q - DW'(1));

    assign full  = (depth_q == DW'(DEPTH));
    assign empty = (depth_q == '0);
    assign depth = depth_q;
    assign top   = mem_q[rd_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            depth_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push && !full) begin
            mem_q[wr_idx] <= din;
            depth_q       <= depth_q + DW'(1);
        end else if (pop && !empty) begin
            depth_q <= depth_q - DW'(1);
        end
    end

endmodule

// File: rtl/frame_ptr_ctrl.sv
// Frame pointer owner: window-relative to physical translation and CALL/RTN moves.
// FP_BOUNDS_CHECK_EN: reject moves whose window would leave registers 0..15.
module frame_ptr_ctrl
    import frame_pkg::*;
(
    input logic             Clock,
    input logic             Reset_n,
    frame_ptr_ctrl_if.slave bus
);

    localparam int EW = ADDR_W + 1;

    fp_state_t  state_q;
    phys_addr_t fp_q;
    phys_addr_t pend_q;
    phys_addr_t new_fp_q;
    win_idx_t   shift_q;
    logic       dir_q;
    logic       move_q;
    logic       busy_q;
    logic       fault_q;

    logic       st_push;
    logic       st_pop;
    logic       st_full;
    logic       st_empty;
    win_idx_t   st_top;
    depth_t     st_depth;

    logic       do_call;
    logic       do_rtn;
    logic       reject;
    logic       call_oob;
    logic       rtn_oob;
    phys_addr_t call_pend;
    phys_addr_t rtn_pend;

    assign call_pend = fp_q + phys_addr_t'(bus.Call_Shift);
    assign rtn_pend  = fp_q - phys_addr_t'(st_top);

`ifdef FP_BOUNDS_CHECK_EN
    logic [EW-1:0] call_end;
    // Last register of the new window must not wrap past 15.
    assign call_end = {1'b0, fp_q} + EW'(bus.Call_Shift) + EW'(WIN_SIZE - 1);
    assign call_oob = (call_end > EW'(NUM_REGS - 1));
    assign rtn_oob  = (fp_q < phys_addr_t'(st_top));
`else
    assign call_oob = 1'b0;
    assign rtn_oob  = 1'b0;
`endif

    always_comb begin
        do_call = 1'b0;
        do_rtn  = 1'b0;
        reject  = 1'b0;
        if (state_q == IDLE) begin
            unique case (1'b1)
                bus.Call_Req && bus.Rtn_Req: begin
                    reject = 1'b1;
                end
                bus.Call_Req && !bus.Rtn_Req: begin
                    reject  = st_full || call_oob;
                    do_call = !(st_full || call_oob);
                end
                bus.Rtn_Req && !bus.Call_Req: begin
                    reject = st_empty || rtn_oob;
                    do_rtn = !(st_empty || rtn_oob);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= IDLE;
            fp_q     <= '0;
            pend_q   <= '0;
            new_fp_q <= '0;
            shift_q  <= '0;
            dir_q    <= 1'b0;
            move_q   <= 1'b0;
            busy_q   <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            fault_q <= reject;
            case (state_q)
                IDLE: begin
                    if (do_call || do_rtn) begin
                        state_q  <= MOVE;
                        dir_q    <= do_call;
                        shift_q  <= do_call ? bus.Call_Shift : st_top;
                        pend_q   <= do_call ? call_pend : rtn_pend;
                        new_fp_q <= do_call ? call_pend : rtn_pend;
                        move_q   <= 1'b1;
                        busy_q   <= 1'b1;
                    end
                end
                MOVE: begin
                    state_q  <= IDLE;
                    fp_q     <= pend_q;
                    new_fp_q <= pend_q;
                    move_q   <= 1'b0;
                    busy_q   <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // LIFO commits on the same edge that retires the move.
    assign st_push = (state_q == MOVE) && dir_q;
    assign st_pop  = (state_q == MOVE) && !dir_q;

    fp_shift_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (WIN_W)
    ) u_stack (
        .clk   (Clock),
        .rst_n (Reset_n),
        .push  (st_push),
        .pop   (st_pop),
        .din   (shift_q),
        .top   (st_top),
        .depth (st_depth),
        .full  (st_full),
        .empty (st_empty)
    );

    assign bus.Rd_Addr    = fp_q + phys_addr_t'(bus.Rd_Rel);
    assign bus.Rs_Addr    = fp_q + phys_addr_t'(bus.Rs_Rel);
    assign bus.Rm_Addr    = fp_q + phys_addr_t'(bus.Rm_Rel);
    assign bus.Actual_Rd  = bus.Rd_Rel;
    assign bus.Actual_Rm  = bus.Rm_Rel;
    assign bus.Actual_Rs  = move_q ? shift_q : bus.Rs_Rel;
    assign bus.Rd_Wen     = bus.Rd_Wen_In;
    assign bus.Rs_Wen     = bus.Rs_Wen_In && !move_q;
    assign bus.FP_move    = move_q;
    assign bus.FP_push_up = dir_q;
    assign bus.New_FP     = new_fp_q;
    assign bus.FP         = fp_q;
    assign bus.Busy       = busy_q;
    assign bus.Depth      = st_depth;
    assign bus.Fault      = fault_q;

endmodule

// File: tb/tb_frame_ptr_ctrl.sv
// Scoreboard bench for frame_ptr_ctrl against a behavioural window model.
module tb_frame_ptr_ctrl;

    logic clk;
    logic rst_n;

    frame_ptr_ctrl_if bus ();

    frame_ptr_ctrl dut (
        .Clock   (clk),
        .Reset_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int {
        K_RDA, K_RSA, K_RMA, K_ARD, K_ARS, K_ARM, K_RDW, K_RSW,
        K_MOV, K_PUP, K_NFP, K_FP, K_BSY, K_DEP, K_FLT
    } kind_t;

    typedef struct {
        kind_t k;
        int    v;
        string tag;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_bad   = 0;

    // Reference model state.
    int   m_fp;
    int   m_stk[$];
    bit   m_move;
    bit   m_dir;
    int   m_pend;
    int   m_shift;
    bit   m_fault;

    task automatic chk(input string tag, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int obs(kind_t k);
        case (k)
            K_RDA: return int'(bus.Rd_Addr);
            K_RSA: return int'(bus.Rs_Addr);
            K_RMA: return int'(bus.Rm_Addr);
            K_ARD: return int'(bus.Actual_Rd);
            K_ARS: return int'(bus.Actual_Rs);
            K_ARM: return int'(bus.Actual_Rm);
            K_RDW: return int'(bus.Rd_Wen);
            K_RSW: return int'(bus.Rs_Wen);
            K_MOV: return int'(bus.FP_move);
            K_PUP: return int'(bus.FP_push_up);
            K_NFP: return int'(bus.New_FP);
            K_FP:  return int'(bus.FP);
            K_BSY: return int'(bus.Busy);
            K_DEP: return int'(bus.Depth);
            K_FLT: return int'(bus.Fault);
            default: return -1;
        endcase
    endfunction

    task automatic push_exp(input kind_t k, input int v, input string tag);
        exp_t e;
        e.k = k;
        e.v = v;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.tag, obs(e.k), e.v);
        end
    endtask

    task automatic model_reset();
        m_fp = 0;
        m_stk.delete();
        m_move = 0;
        m_dir = 0;
        m_pend = 0;
        m_shift = 0;
        m_fault = 0;
    endtask

    task automatic expect_now(input int rd, input int rs, input int rm,
                              input bit rdw, input bit rsw);
        push_exp(K_RDA, (m_fp + rd) % 16, "rd_addr");
        push_exp(K_RSA, (m_fp + rs) % 16, "rs_addr");
        push_exp(K_RMA, (m_fp + rm) % 16, "rm_addr");
        push_exp(K_ARD, rd, "actual_rd");
        push_exp(K_ARM, rm, "actual_rm");
        push_exp(K_ARS, m_move ? m_shift : rs, "actual_rs");
        push_exp(K_RDW, int'(rdw), "rd_wen");
        push_exp(K_RSW, m_move ? 0 : int'(rsw), "rs_wen");
        push_exp(K_MOV, int'(m_move), "fp_move");
        push_exp(K_BSY, int'(m_move), "busy");
        push_exp(K_NFP, m_move ? m_pend : m_fp, "new_fp");
        push_exp(K_FP, m_fp, "fp");
        push_exp(K_DEP, m_stk.size(), "depth");
        push_exp(K_FLT, int'(m_fault), "fault");
        if (m_move) push_exp(K_PUP, int'(m_dir), "push_up");
    endtask

    task automatic model_step(input bit c, input bit r, input int sh);
        bit bad_c;
        bit bad_r;
        int top;
        if (m_move) begin
            m_fp = m_pend;
            if (m_dir) m_stk.push_back(m_shift);
            else void'(m_stk.pop_back());
            m_move = 0;
            m_fault = 0;
            return;
        end
        top = (m_stk.size() > 0) ? m_stk[m_stk.size()-1] : 0;
        bad_c = (m_stk.size() >= 4);
        bad_r = (m_stk.size() == 0);
`ifdef FP_BOUNDS_CHECK_EN
        if (m_fp + sh + 7 > 15) bad_c = 1;
        if (m_fp - top < 0) bad_r = 1;
`endif
        m_fault = 0;
        if (c && r) begin
            m_fault = 1;
        end else if (c) begin
            if (bad_c) m_fault = 1;
            else begin
                m_move = 1; m_dir = 1; m_shift = sh;
                m_pend = (m_fp + sh) % 16;
            end
        end else if (r) begin
            if (bad_r) m_fault = 1;
            else begin
                m_move = 1; m_dir = 0; m_shift = top;
                m_pend = (m_fp - top + 16) % 16;
            end
        end
    endtask

    // One clock of stimulus, entered and left at the falling edge.
    task automatic cyc(input bit c, input bit r, input int sh,
                       input int rd, input int rs, input int rm,
                       input bit rdw, input bit rsw);
        bus.Call_Req   = c;
        bus.Rtn_Req    = r;
        bus.Call_Shift = 3'(sh);
        bus.Rd_Rel     = 3'(rd);
        bus.Rs_Rel     = 3'(rs);
        bus.Rm_Rel     = 3'(rm);
        bus.Rd_Wen_In  = rdw;
        bus.Rs_Wen_In  = rsw;
        expect_now(rd, rs, rm, rdw, rsw);
        #1;
        drain();
        model_step(c, r, sh);
        @(negedge clk);
    endtask

    task automatic idle(input int rd);
        cyc(0, 0, 0, rd, 1, 6, 1, 1);
    endtask

    task automatic call(input int sh);
        cyc(1, 0, sh, 0, 2, 4, 0, 0);
    endtask

    task automatic rtn();
        cyc(0, 1, 0, 0, 2, 4, 0, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        push_exp(K_FP, 0, "rst_fp");
        push_exp(K_DEP, 0, "rst_depth");
        push_exp(K_MOV, 0, "rst_fp_move");
        push_exp(K_BSY, 0, "rst_busy");
        push_exp(K_FLT, 0, "rst_fault");
        push_exp(K_NFP, 0, "rst_new_fp");
        #1;
        drain();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.Call_Req = 0;
        bus.Rtn_Req = 0;
        bus.Call_Shift = '0;
        bus.Rd_Rel = '0;
        bus.Rs_Rel = '0;
        bus.Rm_Rel = '0;
        bus.Rd_Wen_In = 0;
        bus.Rs_Wen_In = 0;
        model_reset();
        @(negedge clk);
        do_reset();

        idle(5);
        call(3);
        cyc(0, 0, 0, 1, 5, 2, 1, 1);
        idle(2);
        rtn();
        cyc(1, 0, 6, 3, 4, 7, 1, 1);
        idle(7);

        for (int i = 0; i < 4; i++) begin
            call(1);
            idle(i);
        end
        call(1);
        idle(0);
        idle(3);
        for (int i = 0; i < 4; i++) begin
            rtn();
            idle(i + 2);
        end

        rtn();
        idle(4);
        cyc(1, 1, 5, 6, 0, 3, 1, 0);
        idle(1);

        call(7);
        idle(0);
        call(2);
        idle(6);
        idle(6);

        call(0);
        idle(2);
        idle(2);

        for (int i = 0; i < 80; i++) begin
            cyc(($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
                int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        do_reset();
        idle(0);
        call(5);
        do_reset();
        idle(2);
        idle(2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
